// File: rtl/load_store_unit.sv
// Load/store sequencer between the memory-access stage and a word-wide data memory.
// Issues word-aligned accesses, does read-modify-write for SB/SH and extends loaded lanes.
module load_store_unit (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        Req_i,
  input  logic        IsStore_i,
  input  logic [2:0]  Funct3_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] StoreData_i,
  output logic        Busy_o,
  output logic        Done_o,
  output logic        Error_o,
  output logic [31:0] LoadData_o,
  output logic [31:0] Mem_Address_o,
  output logic [31:0] Mem_WriteData_o,
  output logic        Mem_ReadEn_o,
  output logic        Mem_WriteEn_o,
  input  logic [31:0] Mem_Data_i
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStore,
    StRmwRd,
    StRmwWr,
    StResp
  } state_e;

  state_e      stateQ, stateD;
  logic [2:0]  funct3Q;
  logic [1:0]  offsetQ;
  logic        errorQ;
  logic [31:0] loadDataQ;
  logic [31:0] memAddrQ;
  logic [31:0] memWDataQ;

  logic        reqError;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;
  logic [31:0] loadExt;
  logic [31:0] mergedWord;

  // Illegal width code or misalignment for the request presented in IDLE.
  always_comb begin
    reqError = 1'b0;
    if (IsStore_i) begin
      case (Funct3_i)
        3'b000:  reqError = 1'b0;
        3'b001:  reqError = Addr_i[0];
        3'b010:  reqError = |Addr_i[1:0];
        default: reqError = 1'b1;
      endcase
    end else begin
      case (Funct3_i)
        3'b000, 3'b100: reqError = 1'b0;
        3'b001, 3'b101: reqError = Addr_i[0];
        3'b010:         reqError = |Addr_i[1:0];
        default:        reqError = 1'b1;
      endcase
    end
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle: begin
        if (Req_i) begin
          if (reqError) begin
            stateD = StResp;
          end else if (!IsStore_i) begin
            stateD = StLoad;
          end else if (Funct3_i == 3'b010) begin
            stateD = StStore;
          end else begin
            stateD = StRmwRd;
          end
        end
      end
      StLoad:  stateD = StResp;
      StStore: stateD = StResp;
      StRmwRd: stateD = StRmwWr;
      StRmwWr: stateD = StResp;
      StResp:  stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  // funct3[2] distinguishes the unsigned load variants.
  always_comb begin
    byteSel = Mem_Data_i[{offsetQ, 3'b000} +: 8];
    halfSel = Mem_Data_i[{offsetQ[1], 4'b0000} +: 16];
    loadExt = Mem_Data_i;
    case (funct3Q[1:0])
      2'b00:   loadExt = {{24{byteSel[7] & ~funct3Q[2]}}, byteSel};
      2'b01:   loadExt = {{16{halfSel[15] & ~funct3Q[2]}}, halfSel};
      default: loadExt = Mem_Data_i;
    endcase
  end

  // memWDataQ still holds the raw store source while in RMW_RD.
  always_comb begin
    mergedWord = Mem_Data_i;
    if (funct3Q[0]) begin
      mergedWord[{offsetQ[1], 4'b0000} +: 16] = memWDataQ[15:0];
    end else begin
      mergedWord[{offsetQ, 3'b000} +: 8] = memWDataQ[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      stateQ    <= StIdle;
      funct3Q   <= 3'b000;
      offsetQ   <= 2'b00;
      errorQ    <= 1'b0;
      loadDataQ <= 32'h0;
      memAddrQ  <= 32'h0;
      memWDataQ <= 32'h0;
    end else begin
      stateQ <= stateD;
      if (stateQ == StIdle && Req_i) begin
        funct3Q  <= Funct3_i;
        offsetQ  <= Addr_i[1:0];
        errorQ   <= reqError;
        memAddrQ <= {Addr_i[31:2], 2'b00};
        if (IsStore_i && !reqError) begin
          memWDataQ <= StoreData_i;
        end
      end
      if (stateQ == StLoad) begin
        loadDataQ <= loadExt;
      end
      if (stateQ == StRmwRd) begin
        memWDataQ <= mergedWord;
      end
    end
  end

  assign Busy_o          = (stateQ != StIdle);
  assign Done_o          = (stateQ == StResp);
  assign Error_o         = (stateQ == StResp) & errorQ;
  assign LoadData_o      = loadDataQ;
  assign Mem_Address_o   = memAddrQ;
  assign Mem_WriteData_o = memWDataQ;
  assign Mem_ReadEn_o    = (stateQ == StLoad) | (stateQ == StRmwRd);
  assign Mem_WriteEn_o   = (stateQ == StStore) | (stateQ == StRmwWr);

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table, scoreboard queue and a small
// word memory model, plus hand-written reset-abort and back-to-back request sequences.
module tb_load_store_unit;

  logic        clk;
  logic        rst_i;
  logic        Req_i;
  logic        IsStore_i;
  logic [2:0]  Funct3_i;
  logic [31:0] Addr_i;
  logic [31:0] StoreData_i;
  logic        Busy_o;
  logic        Done_o;
  logic        Error_o;
  logic [31:0] LoadData_o;
  logic [31:0] Mem_Address_o;
  logic [31:0] Mem_WriteData_o;
  logic        Mem_ReadEn_o;
  logic        Mem_WriteEn_o;
  logic [31:0] Mem_Data_i;

  load_store_unit dut (
    .clk             (clk),
    .rst_i           (rst_i),
    .Req_i           (Req_i),
    .IsStore_i       (IsStore_i),
    .Funct3_i        (Funct3_i),
    .Addr_i          (Addr_i),
    .StoreData_i     (StoreData_i),
    .Busy_o          (Busy_o),
    .Done_o          (Done_o),
    .Error_o         (Error_o),
    .LoadData_o      (LoadData_o),
    .Mem_Address_o   (Mem_Address_o),
    .Mem_WriteData_o (Mem_WriteData_o),
    .Mem_ReadEn_o    (Mem_ReadEn_o),
    .Mem_WriteEn_o   (Mem_WriteEn_o),
    .Mem_Data_i      (Mem_Data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 16-word memory; garbage on the read bus when not reading.
  logic [31:0] mem [16];
  assign Mem_Data_i = Mem_ReadEn_o ? mem[Mem_Address_o[5:2]] : 32'hA5A5_A5A5;
  always @(posedge clk) begin
    if (Mem_WriteEn_o) mem[Mem_Address_o[5:2]] <= Mem_WriteData_o;
  end

  int writesSeen = 0;
  int donesSeen  = 0;
  always @(posedge clk) begin
    if (Mem_WriteEn_o) writesSeen <= writesSeen + 1;
    if (Done_o) donesSeen <= donesSeen + 1;
  end

  int checks   = 0;
  int failures = 0;
  logic [31:0] lastLoad = 32'h0;

  typedef struct {
    logic        isLoad;
    logic        err;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic        eErr;
    int          eLat;
    int          eRd;
    int          eWr;
    logic [31:0] eVal;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] data, input logic eErr, input int eLat,
                              input int eRd, input int eWr, input logic [31:0] eVal);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = addr; v.data = data; v.eErr = eErr;
    v.eLat = eLat; v.eRd = eRd; v.eWr = eWr; v.eVal = eVal;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chkOutsZero(input string nm);
    chk({nm, ".ctrl"}, 32'({Busy_o, Done_o, Error_o, Mem_ReadEn_o, Mem_WriteEn_o}), 32'h0);
    chk({nm, ".loadData"}, LoadData_o, 32'h0);
    chk({nm, ".memAddr"}, Mem_Address_o, 32'h0);
    chk({nm, ".memWData"}, Mem_WriteData_o, 32'h0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the following idle cycle.
  task automatic runTxn(input string nm, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data, input logic eErr,
                        input logic [31:0] eLoad, input bit holdReq, output int lat,
                        output int rd, output int wr, output logic [31:0] wdata,
                        output logic [31:0] maddr);
    exp_t e;
    logic both;
    lat = 0; rd = 0; wr = 0; wdata = 32'h0; maddr = 32'h0; both = 1'b0;
    IsStore_i = st; Funct3_i = f3; Addr_i = addr; StoreData_i = data; Req_i = 1'b1;
    e.isLoad = !st && !eErr;
    e.err    = eErr;
    e.data   = e.isLoad ? eLoad : lastLoad;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (!holdReq) Req_i = 1'b0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (Mem_ReadEn_o && Mem_WriteEn_o) both = 1'b1;
      if (Mem_ReadEn_o) begin rd++; maddr = Mem_Address_o; end
      if (Mem_WriteEn_o) begin wr++; wdata = Mem_WriteData_o; maddr = Mem_Address_o; end
      if (Done_o) lat = c;
    end
    chk({nm, ".exclusive"}, 32'(both), 32'h0);
    if (lat == 0) begin
      checks++;
      failures++;
      $display("FAIL %s.timeout actual=no Done_o required=Done_o within 8 cycles", nm);
      sbq.delete();
    end else begin
      e = sbq.pop_front();
      chk({nm, ".error"}, 32'(Error_o), 32'(e.err));
      chk({nm, ".loadData"}, LoadData_o, e.data);
      if (e.isLoad) lastLoad = e.data;
    end
    @(negedge clk);
    chk({nm, ".idleGap"}, 32'(Busy_o), 32'h0);
  endtask

  vec_t vecs[$];
  int lat, rd, wr;
  logic [31:0] wdata, maddr;
  int wrBefore, doneBefore;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    rst_i = 1'b1; Req_i = 1'b0; IsStore_i = 1'b0; Funct3_i = 3'b000;
    Addr_i = 32'h0; StoreData_i = 32'h0;
    #3;
    chkOutsZero("reset");
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    chkOutsZero("postReset");

    //             st f3    addr          data          err lat rd wr value
    vecs.push_back(mk(1, 3'd2, 32'h10,       32'hDEADBEEF, 0, 2, 0, 1, 32'hDEADBEEF));
    vecs.push_back(mk(0, 3'd2, 32'h10,       32'h0,        0, 2, 1, 0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 3'd0, 32'h13,       32'h0,        0, 2, 1, 0, 32'hFFFFFFDE));
    vecs.push_back(mk(0, 3'd4, 32'h13,       32'h0,        0, 2, 1, 0, 32'h000000DE));
    vecs.push_back(mk(0, 3'd1, 32'h12,       32'h0,        0, 2, 1, 0, 32'hFFFFDEAD));
    vecs.push_back(mk(0, 3'd5, 32'h10,       32'h0,        0, 2, 1, 0, 32'h0000BEEF));
    vecs.push_back(mk(1, 3'd0, 32'h11,       32'h12345677, 0, 3, 1, 1, 32'hDEAD77EF));
    vecs.push_back(mk(0, 3'd2, 32'h10,       32'h0,        0, 2, 1, 0, 32'hDEAD77EF));
    vecs.push_back(mk(0, 3'd2, 32'h12,       32'h0,        1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 3'd1, 32'h13,       32'h5555,     1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 3'd3, 32'h10,       32'h0,        1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 3'd4, 32'h10,       32'h1,        1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 3'd5, 32'h11,       32'h0,        1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 3'd1, 32'h12,       32'h0000AAAA, 0, 3, 1, 1, 32'hAAAA77EF));
    vecs.push_back(mk(0, 3'd0, 32'h11,       32'h0,        0, 2, 1, 0, 32'h00000077));
    vecs.push_back(mk(1, 3'd2, 32'hFFFFFFFC, 32'h80000001, 0, 2, 0, 1, 32'h80000001));
    vecs.push_back(mk(0, 3'd5, 32'hFFFFFFFE, 32'h0,        0, 2, 1, 0, 32'h00008000));
    vecs.push_back(mk(0, 3'd0, 32'hFFFFFFFF, 32'h0,        0, 2, 1, 0, 32'hFFFFFF80));
    vecs.push_back(mk(1, 3'd0, 32'h13,       32'h000000FF, 0, 3, 1, 1, 32'hFFAA77EF));
    vecs.push_back(mk(0, 3'd0, 32'h12,       32'h0,        0, 2, 1, 0, 32'hFFFFFFAA));
    vecs.push_back(mk(0, 3'd5, 32'h12,       32'h0,        0, 2, 1, 0, 32'h0000FFAA));

    foreach (vecs[i]) begin
      runTxn($sformatf("v%0d", i), vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].data,
             vecs[i].eErr, vecs[i].eVal, 1'b0, lat, rd, wr, wdata, maddr);
      chk($sformatf("v%0d.latency", i), 32'(lat), 32'(vecs[i].eLat));
      chk($sformatf("v%0d.reads", i), 32'(rd), 32'(vecs[i].eRd));
      chk($sformatf("v%0d.writes", i), 32'(wr), 32'(vecs[i].eWr));
      if (vecs[i].eWr > 0) chk($sformatf("v%0d.writeData", i), wdata, vecs[i].eVal);
      if (vecs[i].eRd + vecs[i].eWr > 0)
        chk($sformatf("v%0d.memAddr", i), maddr, vecs[i].addr & 32'hFFFFFFFC);
    end

    // Reset while an SH sits in RMW_RD: no write, no Done, memory keeps the prior word.
    wrBefore = writesSeen;
    doneBefore = donesSeen;
    IsStore_i = 1'b1; Funct3_i = 3'd1; Addr_i = 32'h10; StoreData_i = 32'h0000AAAA;
    Req_i = 1'b1;
    @(posedge clk);
    #1;
    Req_i = 1'b0;
    chk("abort.readEn", 32'(Mem_ReadEn_o), 32'h1);
    #2;
    rst_i = 1'b1;
    #1;
    chkOutsZero("abort");
    @(negedge clk);
    rst_i = 1'b0;
    lastLoad = 32'h0;
    repeat (3) @(negedge clk);
    chk("abort.noWrite", 32'(writesSeen - wrBefore), 32'h0);
    chk("abort.noDone", 32'(donesSeen - doneBefore), 32'h0);
    runTxn("abort.lw", 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'hFFAA77EF, 1'b0,
           lat, rd, wr, wdata, maddr);
    chk("abort.lw.latency", 32'(lat), 32'd2);

    // Req_i held high with alternating SW/LW.
    for (int i = 0; i < 4; i++) begin
      logic [31:0] d;
      d = 32'h9111_0000 + 32'(i * 32'h1357);
      runTxn($sformatf("b2b%0d.sw", i), 1'b1, 3'd2, 32'h20, d, 1'b0, 32'h0, 1'b1,
             lat, rd, wr, wdata, maddr);
      chk($sformatf("b2b%0d.sw.shape", i), 32'({lat[3:0], rd[3:0], wr[3:0]}), 32'h201);
      chk($sformatf("b2b%0d.sw.data", i), wdata, d);
      runTxn($sformatf("b2b%0d.lw", i), 1'b0, 3'd2, 32'h20, 32'h0, 1'b0, d, 1'b1,
             lat, rd, wr, wdata, maddr);
      chk($sformatf("b2b%0d.lw.shape", i), 32'({lat[3:0], rd[3:0], wr[3:0]}), 32'h210);
    end
    Req_i = 1'b0;
    @(negedge clk);
    chk("final.sbqEmpty", 32'(sbq.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencing stage between the core's memory-access stage and the word-wide, byte-addressed data memory. Accepts one load or store request at a time and issues word-aligned memory accesses. Performs read-modify-write for byte and halfword stores, and byte-lane extraction with sign or zero extension for loads. Flags misaligned and illegal accesses without touching memory.

## Interface
- No parameters; data and address widths fixed at 32.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` input 1: clock; all state changes on rising edge.
- `rst_i` input 1: asynchronous active-high reset.
- `Req_i` input 1: request strobe; sampled only in IDLE.
- `IsStore_i` input 1: 1 = store, 0 = load.
- `Funct3_i` input 3: RISC-V width code.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `Addr_i` input 32: byte address.
- `StoreData_i` input 32: store source; low byte or halfword used for SB/SH.
- `Busy_o` output 1: high whenever state is not IDLE.
- `Done_o` output 1: one-cycle completion pulse.
- `Error_o` output 1: valid with `Done_o`; misaligned or illegal `Funct3_i`.
- `LoadData_o` output 32: extended load result; valid with `Done_o` for loads, held until the next load completes.
- `Mem_Address_o` output 32: word-aligned address; bits [1:0] always 00.
- `Mem_WriteData_o` output 32: word to write.
- `Mem_ReadEn_o` output 1: memory read enable.
- `Mem_WriteEn_o` output 1: memory write enable.
- `Mem_Data_i` input 32: memory read data; valid by end of the cycle in which `Mem_ReadEn_o` is high.

## Operation
- States: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- IDLE with `Req_i`=1:
  - Latch `IsStore_i`, `Funct3_i`, `Addr_i`, `StoreData_i`.
  - `Mem_Address_o` <= {`Addr_i`[31:2], 00}.
- IDLE next-state decode:
  - Error → RESP. Error = illegal code (loads: 011/110/111; stores: anything but 000/001/010), or halfword with addr[0]=1, or word with addr[1:0]≠00.
  - Load → LOAD.
  - SW → STORE.
  - SB/SH → RMW_RD.
- LOAD: `Mem_ReadEn_o`=1. At the closing edge, capture `Mem_Data_i`, extract the lane, extend into `LoadData_o`, go to RESP.
  - Byte lane = addr[1:0]; halfword lane = addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- STORE: `Mem_WriteEn_o`=1, `Mem_WriteData_o` = latched data; → RESP.
- RMW_RD: `Mem_ReadEn_o`=1. At the closing edge, merge into `Mem_WriteData_o`; → RMW_WR.
  - SB replaces bits [8k+7:8k], k = addr[1:0].
  - SH replaces bits [16h+15:16h], h = addr[1].
- RMW_WR: `Mem_WriteEn_o`=1; → RESP.
- RESP: `Done_o`=1, `Error_o` = latched error flag; → IDLE.
- `Req_i` while busy is ignored, not queued. Caller holds or re-issues after `Done_o`.
- `Mem_ReadEn_o` and `Mem_WriteEn_o` are decoded from state. They are never high together, and both are 0 on the error path.

## Timing
- Request sampled at edge E0.
- Completion latency:
  - Load: `Done_o` high in cycle E1–E2 (LOAD, RESP).
  - SW: `Done_o` high in cycle E1–E2.
  - SB/SH: `Done_o` high in cycle E2–E3.
  - Error: `Done_o` high in cycle E0–E1.
- Next request accepted at the first edge after RESP (IDLE).
- Reset values: state IDLE; `Busy_o`, `Done_o`, `Error_o`, `Mem_ReadEn_o`, `Mem_WriteEn_o` = 0; `LoadData_o`, `Mem_Address_o`, `Mem_WriteData_o` = 0.
- Reset mid-operation: enables drop immediately (asynchronously) and state returns to IDLE.
  - No `Done_o` is issued for the aborted request.
  - An RMW aborted before the RMW_WR closing edge leaves memory unchanged.
- Address wrap: `Addr_i` 0xFFFFFFFC–0xFFFFFFFF maps to word 0xFFFFFFFC; no carry beyond bit 31.

## Test plan
- Reset: assert `rst_i` mid-cycle → every output 0 before the next edge; `Busy_o`=0.
- SW 0x10 data 0xDEADBEEF, then reads of 0x10–0x13:
  - LW 0x10 → 0xDEADBEEF.
  - LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE.
  - LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF.
  - Each `Done_o` at the second edge after acceptance.
- SB 0x11 data 0x12345677 → one read cycle, then one write cycle with `Mem_WriteData_o`=0xDEAD77EF; `Done_o` at the third edge after acceptance; LW 0x10 → 0xDEAD77EF.
- Errors: LW 0x12, SH 0x13, load `Funct3_i`=011, store `Funct3_i`=100 → each gives `Done_o`=1 and `Error_o`=1 in the cycle after acceptance, with zero memory enables.
- Reset during RMW_RD of SH 0x10 data 0xAAAA → `Mem_WriteEn_o` never asserted; LW 0x10 after reset returns the prior word.
- `Req_i` held high continuously with alternating SW/LW → each request accepted only from IDLE; no duplicate or dropped accesses; `Busy_o` low exactly one cycle between requests.
